// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed seven-segment display scanner.
// Segment encodings are active-low: bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
package disp_pkg;

  localparam int unsigned DIGIT_W = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Digit 0..9 patterns with the decimal point off.
  localparam logic [7:0] SEG_LUT [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder: values above 9 show a dash,
// blank forces every segment (including dp) off.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] value,
  input  logic               dp_en,
  input  logic               blank,
  output logic [7:0]         seg
);

  always_comb begin
    seg = SEG_DASH;
    if (value < DIGIT_W'(10)) begin
      seg = SEG_LUT[value[3:0]];
    end
    seg[7] = ~dp_en;
    if (blank) begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/disp_scan.sv
// Six-digit common-anode display scanner with frame-coherent digit snapshot,
// anti-ghost guard interval, per-digit blink and hours-tens zero blanking.
module disp_scan
  import disp_pkg::*;
#(
  parameter int unsigned       DIGITS    = 6,
  parameter int unsigned       SCAN_DIV  = 1000,
  parameter int unsigned       GUARD     = 8,
  parameter int unsigned       BLINK_DIV = 64,
  parameter logic [DIGITS-1:0] DP_MASK   = 6'b010100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DIGIT_W*DIGITS-1:0] digits_in,
  input  logic [DIGITS-1:0]         blink_mask,
  input  logic                      blank_lz,
  output logic [DIGITS-1:0]         an,
  output logic [7:0]                seg,
  output logic                      frame_start
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned IDX_W = (DIGITS > 1)    ? $clog2(DIGITS)    : 1;
  localparam int unsigned FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]   idx;
  logic [FRM_W-1:0]   frame_cnt;
  logic               blink_ph;
  logic [DIGIT_W-1:0] snap [DIGITS];

  logic               slot_end_c;
  logic               frame_end_c;
  logic               last_idx_c;
  logic               guard_c;
  logic               blank_c;
  logic [DIGIT_W-1:0] cur_digit_c;
  logic [DIGITS-1:0]  an_c;
  logic [7:0]         seg_c;

  always_comb begin
    last_idx_c  = (idx == IDX_W'(DIGITS - 1));
    slot_end_c  = (scan_cnt == CNT_W'(SCAN_DIV - 1));
    frame_end_c = slot_end_c && last_idx_c;
    guard_c     = (scan_cnt < CNT_W'(GUARD));
    cur_digit_c = snap[idx];
    an_c        = ~(DIGITS'(1) << idx);
    blank_c     = (blink_ph && blink_mask[idx]) ||
                  (blank_lz && last_idx_c && (cur_digit_c == '0));
  end

  seg7_decode u_decode (
    .value (cur_digit_c),
    .dp_en (DP_MASK[idx]),
    .blank (blank_c),
    .seg   (seg_c)
  );

  // Slot/digit counters, frame snapshot and blink phase all advance together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
      for (int k = 0; k < int'(DIGITS); k++) begin
        snap[k] <= '0;
      end
    end else begin
      scan_cnt <= slot_end_c ? '0 : scan_cnt + CNT_W'(1);
      if (slot_end_c) begin
        idx <= last_idx_c ? '0 : idx + IDX_W'(1);
      end
      if (frame_end_c) begin
        for (int k = 0; k < int'(DIGITS); k++) begin
          snap[k] <= digits_in[k*DIGIT_W +: DIGIT_W];
        end
        if (frame_cnt == FRM_W'(BLINK_DIV - 1)) begin
          frame_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          frame_cnt <= frame_cnt + FRM_W'(1);
        end
      end
    end
  end

  // Display outputs lag the scan position by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an          <= '1;
      seg         <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end_c;
      if (guard_c) begin
        an  <= '1;
        seg <= SEG_BLANK;
      end else begin
        an  <= an_c;
        seg <= seg_c;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Scoreboard bench for disp_scan: a time-indexed reference model predicts each
// cycle's display outputs; a monitor compares them as the DUT produces them.
module tb_disp_scan;

  localparam int unsigned DIGITS    = 6;
  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned GUARD     = 1;
  localparam int unsigned BLINK_DIV = 2;
  localparam logic [5:0]  DP_MASK   = 6'b001010;
  localparam int          FRAME_LEN = SCAN_DIV * DIGITS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] digits_in;
  logic [5:0]  blink_mask;
  logic        blank_lz;
  logic [5:0]  an;
  logic [7:0]  seg;
  logic        frame_start;

  disp_scan #(
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .GUARD     (GUARD),
    .BLINK_DIV (BLINK_DIV),
    .DP_MASK   (DP_MASK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits_in   (digits_in),
    .blink_mask  (blink_mask),
    .blank_lz    (blank_lz),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  an;
    logic [7:0]  seg;
    logic        fs;
    logic [31:0] t;
  } exp_t;

  exp_t       q[$];
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [7:0] snap_m [6];
  int         t_m = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input int tt, input logic [7:0] got,
                     input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at t=%0d: got %h, expected %h", name, tt, got, want);
    end
  endtask

  // Predict the outputs for the coming clock edge, then advance to the next negedge.
  task automatic cycle();
    exp_t       e;
    int         slot, pos, idx, fr;
    logic [7:0] val, pat;
    bit         ph, blank;
    e = '0;
    if (!rst_n) begin
      e.an = 6'h3F; e.seg = 8'hFF; e.fs = 1'b0; e.t = 32'hFFFF_FFFF;
      t_m = 0;
      for (int k = 0; k < 6; k++) snap_m[k] = 8'h00;
    end else begin
      slot = t_m / SCAN_DIV;
      pos  = t_m % SCAN_DIV;
      idx  = slot % DIGITS;
      fr   = slot / DIGITS;
      ph   = ((fr / BLINK_DIV) % 2) == 1;
      e.t  = t_m;
      e.fs = ((t_m + 1) % FRAME_LEN) == 0;
      if (pos < GUARD) begin
        e.an = 6'h3F; e.seg = 8'hFF;
      end else begin
        e.an  = ~(6'd1 << idx);
        val   = snap_m[idx];
        blank = (ph && blink_mask[idx]) || (blank_lz && idx == 5 && val == 0);
        if (val < 10) begin
          pat = seg_tab[val];
          e.seg = {~DP_MASK[idx], pat[6:0]};
        end else begin
          e.seg = {~DP_MASK[idx], 7'h3F};
        end
        if (blank) e.seg = 8'hFF;
      end
      if (e.fs)
        for (int k = 0; k < 6; k++) snap_m[k] = digits_in[k*8 +: 8];
      t_m++;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_dig(input logic [7:0] d5, d4, d3, d2, d1, d0);
    digits_in = {d5, d4, d3, d2, d1, d0};
  endtask

  function automatic logic [7:0] rnd_digit();
    if ($urandom_range(0, 7) == 0) return 8'($urandom_range(10, 255));
    return 8'($urandom_range(0, 9));
  endfunction

  task automatic rnd_digits();
    for (int k = 0; k < 6; k++) begin
      digits_in[k*8 +: 8] = rnd_digit();
      if (k == 5 && $urandom_range(0, 2) == 0) digits_in[47:40] = 8'd0;
    end
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0)  rnd_digits();
      if ($urandom_range(0, 39) == 0) blink_mask = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
      cycle();
    end
  endtask

  // Monitor: every output cycle is compared against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("an", int'(e.t), {2'b00, an}, {2'b00, e.an});
        chk("seg", int'(e.t), seg, e.seg);
        chk("frame_start", int'(e.t), {7'd0, frame_start}, {7'd0, e.fs});
      end
    end
  end

  initial begin
    int guard_n;
    rst_n = 1'b0; digits_in = '0; blink_mask = '0; blank_lz = 1'b1;
    run(3);
    rst_n = 1'b1;
    run(2 * FRAME_LEN);

    blank_lz = 1'b0;
    set_dig(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);
    run(3 * FRAME_LEN);

    set_dig(8'd9, 8'd8, 8'd7, 8'd0, 8'd1, 8'd2);
    run(FRAME_LEN / 2);
    set_dig(8'd0, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3);
    run(2 * FRAME_LEN);

    set_dig(8'd1, 8'd2, 8'd3, 8'd12, 8'd200, 8'd6);
    run(2 * FRAME_LEN);

    set_dig(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);
    blink_mask = 6'b000011;
    run(8 * FRAME_LEN);
    blink_mask = '0;

    run_random(2000);

    // Reset for one cycle in the middle of the digit-3 slot.
    blank_lz = 1'b0;
    guard_n = 0;
    while (!(((t_m / SCAN_DIV) % DIGITS) == 3 && (t_m % SCAN_DIV) == 1) && guard_n < 200) begin
      cycle();
      guard_n++;
    end
    chk("reach_idx3", guard_n, {7'd0, guard_n < 200}, 8'd1);
    set_dig(8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    run(3 * FRAME_LEN);

    run_random(1000);

    chk("queue_drained", 0, 8'(q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
